// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the program counter, issues in-order word
// requests to instruction memory, pairs each returned word with its PC and
// buffers it in a small FIFO that feeds decode.
//
// Handshakes: every channel uses valid/ready. A transfer happens on a rising
// edge where both valid and ready are high. A source that has raised valid
// keeps its payload stable until that transfer happens. Valid never depends
// combinationally on the ready of the same channel.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus
);

  localparam int              CW       = $clog2(DEPTH + 1);
  localparam int              PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]   LAST_IDX = PW'(DEPTH - 1);
  localparam logic [CW:0]     CREDITS  = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] pq_wr;
  logic [PW-1:0] pq_rd;
  logic [31:0]   fifo_word [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];
  logic [31:0]   pc_q      [DEPTH];
  logic          has_credit;
  logic          req_fire;
  logic          resp_keep;
  logic          push;
  logic          pop;

  // The two low bits of a redirect target are ignored; fetch is word aligned.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PW'(1);
  endfunction

  // Request issue, handshake qualifiers and head-of-FIFO outputs.
  // Credit ignores a same-cycle pop so imem_req_valid has no path from
  // instr_ready or the response channel.
  always_comb begin
    has_credit     = ({1'b0, count} + {1'b0, inflight}) < CREDITS;
    imem_req_valid = !rst && !halt && !redirect && has_credit;
    imem_req_addr  = fetch_pc;
    req_fire       = imem_req_valid && imem_req_ready;
    instr_valid    = (count != '0);
    pop            = instr_valid && instr_ready && !redirect;
    resp_keep      = imem_resp_valid && (drop == '0);
    push           = resp_keep && !redirect;
    instruction    = instr_valid ? fifo_word[rd_ptr] : '0;
    instr_pc       = instr_valid ? fifo_pc[rd_ptr] : '0;
    instr_pc_plus  = instr_pc + 32'd4;
  end

  // Program counter: redirect wins, otherwise advance one word per accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
    end else if (req_fire) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // Outstanding-request and stale-response counters; everything accepted
  // before a redirect becomes stale, minus a response landing that same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
      drop     <= '0;
    end else begin
      case ({req_fire, imem_resp_valid})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
      if (redirect) begin
        drop <= inflight - CW'(imem_resp_valid);
      end else if (imem_resp_valid && (drop != '0)) begin
        drop <= drop - CW'(1);
      end
    end
  end

  // PC queue pointers: one entry per outstanding request, popped by every
  // response (kept or dropped) so responses stay paired with their address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pq_wr <= '0;
      pq_rd <= '0;
    end else begin
      if (req_fire) begin
        pq_wr <= ptr_inc(pq_wr);
      end
      if (imem_resp_valid) begin
        pq_rd <= ptr_inc(pq_rd);
      end
    end
  end

  // Instruction FIFO pointers and occupancy; a redirect empties it and
  // overrides any same-cycle push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      wr_ptr <= rd_ptr;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage arrays; contents are only observed through valid entries.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      pc_q[pq_wr] <= fetch_pc;
    end
    if (push) begin
      fifo_word[wr_ptr] <= imem_resp_data;
      fifo_pc[wr_ptr]   <= pc_q[pq_rd];
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: in-order memory model with configurable
// latency, a scoreboard of expected {pc, word} pairs and directed scenarios
// for streaming, backpressure, redirects, halt, async reset and PC wrap.
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data  = '0;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .halt            (halt),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instruction     (instruction),
    .instr_pc        (instr_pc),
    .instr_pc_plus   (instr_pc_plus)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       memq[$];
  logic [63:0] exp_q[$];
  logic [63:0] exp_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  int          model_inflight = 0;
  int          accept_cnt = 0;
  int          out_cnt = 0;
  logic [31:0] model_pc = RESET_PC;
  logic [31:0] last_accept_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- memory model + scoreboard ----------------
  initial begin : mem_and_scoreboard
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst && (memq.size() != 0) && (memq[0].due <= cyc)) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(memq[0].addr);
        void'(memq.pop_front());
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
      end
      @(negedge clk);
      if (rst) begin
        memq.delete();
        exp_q.delete();
        model_inflight = 0;
        model_pc       = RESET_PC;
      end else begin
        if (instr_valid && instr_ready && !redirect) begin
          out_cnt++;
          check_eq("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            exp_e = exp_q.pop_front();
            check_eq("out_pc", instr_pc, exp_e[63:32]);
            check_eq("out_word", instruction, exp_e[31:0]);
            check_eq("out_pc_plus", instr_pc_plus, exp_e[63:32] + 32'd4);
          end
        end
        if (imem_resp_valid) model_inflight--;
        if (redirect) begin
          check_eq("no_req_on_redirect", 32'(imem_req_valid), 32'd0);
          exp_q.delete();
          model_pc = {redirect_pc[31:2], 2'b00};
        end
        if (imem_req_valid && imem_req_ready) begin
          check_eq("req_addr", imem_req_addr, model_pc);
          memq.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
          exp_q.push_back({model_pc, mem_word(model_pc)});
          last_accept_addr = model_pc;
          model_pc = model_pc + 32'd4;
          model_inflight++;
          accept_cnt++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_first_pc(input string tag, input logic [31:0] pc);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (instr_valid) seen = 1'b1;
    end
    check_eq({tag, "_seen"}, 32'(seen), 32'd1);
    check_eq(tag, instr_pc, pc);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    check_eq({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    check_eq({tag, "_req_addr"}, imem_req_addr, RESET_PC);
    check_eq({tag, "_instruction"}, instruction, 32'd0);
    check_eq({tag, "_instr_pc"}, instr_pc, 32'd0);
    check_eq({tag, "_pc_plus"}, instr_pc_plus, 32'd4);
    check_eq({tag, "_count"}, 32'(dut.count), 32'd0);
    check_eq({tag, "_inflight"}, 32'(dut.inflight), 32'd0);
    check_eq({tag, "_drop"}, 32'(dut.drop), 32'd0);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin : main
    bit          found;
    int          exp_drop;
    int          acc0;
    int          out0;
    logic [31:0] exp_next;

    rst = 1'b1; imem_req_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    halt = 1'b0; instr_ready = 1'b0;
    #12;
    check_reset_outputs("reset");

    // Reset release and streaming.
    @(posedge clk); #1;
    rst = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1; mem_lat = 1;
    @(negedge clk);
    check_eq("first_req_valid", 32'(imem_req_valid), 32'd1);
    check_eq("first_req_addr", imem_req_addr, RESET_PC);
    expect_first_pc("stream_first_pc", RESET_PC);
    step_n(20);
    check_eq("stream_progress", 32'(out_cnt >= 10), 32'd1);

    // Backpressure: decode stalls, FIFO fills, issue stops.
    instr_ready = 1'b0;
    step_n(5);
    @(negedge clk);
    check_eq("bp_count", 32'(dut.count), 32'd2);
    check_eq("bp_inflight", 32'(dut.inflight), 32'd0);
    check_eq("bp_req_valid", 32'(imem_req_valid), 32'd0);
    @(posedge clk); #1;
    instr_ready = 1'b1;
    step_n(10);

    // Redirect with two requests outstanding at latency 3.
    mem_lat = 3;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #2;
      if (model_inflight == 2) found = 1'b1;
    end
    check_eq("rd1_two_inflight", 32'(found), 32'd1);
    exp_drop = model_inflight - int'(imem_resp_valid);
    redirect = 1'b1; redirect_pc = 32'h0000_2003;
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    check_eq("rd1_drop", 32'(dut.drop), 32'(exp_drop));
    check_eq("rd1_count", 32'(dut.count), 32'd0);
    check_eq("rd1_instr_valid", 32'(instr_valid), 32'd0);
    check_eq("rd1_next_addr", imem_req_addr, 32'h0000_2000);
    expect_first_pc("rd1_first_pc", 32'h0000_2000);
    step_n(10);

    // Redirect in the same cycle as a response and a pop.
    mem_lat = 2;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #2;
      if (imem_resp_valid && instr_valid) found = 1'b1;
    end
    check_eq("rd2_coincident", 32'(found), 32'd1);
    exp_drop = model_inflight - 1;
    redirect = 1'b1; redirect_pc = 32'h0000_3000;
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    check_eq("rd2_drop", 32'(dut.drop), 32'(exp_drop));
    check_eq("rd2_count", 32'(dut.count), 32'd0);
    check_eq("rd2_instr_valid", 32'(instr_valid), 32'd0);
    expect_first_pc("rd2_first_pc", 32'h0000_3000);
    step_n(10);

    // Halt with exactly one request in flight.
    mem_lat = 3;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #2;
      if (model_inflight == 1) found = 1'b1;
    end
    check_eq("halt_one_inflight", 32'(found), 32'd1);
    halt = 1'b1;
    acc0 = accept_cnt; out0 = out_cnt;
    exp_next = last_accept_addr + 32'd4;
    repeat (10) begin
      @(negedge clk);
      check_eq("halt_no_req", 32'(imem_req_valid), 32'd0);
    end
    check_eq("halt_no_accepts", 32'(accept_cnt), 32'(acc0));
    check_eq("halt_delivered", 32'(out_cnt > out0), 32'd1);
    check_eq("halt_sb_drained", 32'(exp_q.size()), 32'd0);
    check_eq("halt_pc_held", imem_req_addr, exp_next);
    @(posedge clk); #1;
    halt = 1'b0;
    @(negedge clk);
    check_eq("resume_req_valid", 32'(imem_req_valid), 32'd1);
    check_eq("resume_addr", imem_req_addr, exp_next);

    // Asynchronous reset between clock edges mid-stream.
    mem_lat = 1;
    step_n(6);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
    check_eq("post_rst_addr", imem_req_addr, RESET_PC);
    step_n(6);

    // Redirect to the top word: PC wraps to zero.
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    redirect = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) found = 1'b1;
    end
    check_eq("wrap_accept_seen", 32'(found), 32'd1);
    check_eq("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    check_eq("wrap_next_addr", imem_req_addr, 32'h0000_0000);
    expect_first_pc("wrap_first_pc", 32'hFFFF_FFFC);
    check_eq("wrap_pc_plus", instr_pc_plus, 32'h0000_0000);

    // Random ready/redirect traffic.
    mem_lat = 2;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      imem_req_ready = 1'($urandom_range(0, 1));
      instr_ready    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin
        redirect    = 1'b1;
        redirect_pc = $urandom();
      end else begin
        redirect = 1'b0;
      end
    end
    @(posedge clk); #1;
    redirect = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1;
    step_n(10);

    // Drain: stop fetching and everything expected must have come out.
    halt = 1'b1;
    step_n(20);
    @(negedge clk);
    check_eq("final_sb_empty", 32'(exp_q.size()), 32'd0);
    check_eq("final_inflight", 32'(dut.inflight), 32'd0);
    check_eq("final_count", 32'(dut.count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage directly upstream of the control unit: holds the program counter, issues in-order word requests to instruction memory over a valid/ready request channel, and buffers returned words in a small FIFO. Each buffered word is presented to decode with its PC and PC+4 over a valid/ready handshake. Jumps and taken branches redirect the stage through `redirect`/`redirect_pc`, which flushes the buffer and discards in-flight responses. `halt` (driven from the decoded `ebreak`) stops new fetches.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- `DEPTH`, default 2: FIFO entries and maximum outstanding requests; legal range 1..7.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req_valid`  out  1  request to instruction memory is valid.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_req_addr`  out  32  word address of the request; bits [1:0] are always 0.
- `imem_resp_valid`  in  1  one response word is returned this cycle, in request order, at least 1 cycle after acceptance.
- `imem_resp_data`  in  32  returned instruction word.
- `redirect`  in  1  restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  new fetch address; bits [1:0] are ignored and treated as 0.
- `halt`  in  1  level signal; while high, no new requests are issued.
- `instr_valid`  out  1  FIFO head is valid.
- `instr_ready`  in  1  decode consumes the head this cycle.
- `instruction`  out  32  FIFO head word, fed to the control unit.
- `instr_pc`  out  32  address of the head word.
- `instr_pc_plus`  out  32  `instr_pc` + 4, wrapping modulo 2^32.

## Operation
- **State:**
  - `fetch_pc` (32 bits).
  - FIFO of {word, pc} with `count`.
  - `inflight`: accepted requests not yet answered.
  - `drop`: stale responses still to discard, with `drop` ≤ `inflight`.
  - Counters are $clog2(DEPTH+1) bits wide.
- **Reset values:**
  - `fetch_pc` = `RESET_PC`; `count`, `inflight` and `drop` = 0.
  - `imem_req_valid` = 0 and `instr_valid` = 0.
  - `imem_req_addr` = `RESET_PC`, `instruction` = 0, `instr_pc` = 0, `instr_pc_plus` = 4.
- **Request issue:**
  - `imem_req_valid` = !`halt` && !`redirect` && (`count` + `inflight` < `DEPTH`). The credit check is conservative: a same-cycle pop is not counted as freeing space.
  - `imem_req_addr` = `fetch_pc`, which is held stable while valid and not ready.
  - On acceptance, `fetch_pc` += 4 (wrapping) and `inflight` += 1.
  - The request's PC is pushed onto a DEPTH-entry PC queue, so each response is paired with its address.
- **Response:**
  - On `imem_resp_valid`, `inflight` -= 1.
  - If `drop` > 0: the response is discarded and `drop` -= 1.
  - Otherwise {`imem_resp_data`, pc} is pushed into the FIFO. Overflow is impossible by the credit rule.
- **Output:**
  - `instr_valid` = (`count` != 0); data comes from the FIFO head.
  - Pop on `instr_valid` && `instr_ready`.
  - Push and pop in the same cycle are allowed, and `count` is unchanged.
- **Redirect (highest priority):**
  - `fetch_pc` ← {`redirect_pc`[31:2], 2'b00}.
  - The FIFO is emptied (`count` = 0) and any same-cycle pop or push is ignored.
  - `drop` ← `inflight` − `imem_resp_valid`, i.e. every request accepted before the redirect is stale.
  - No request is issued in the redirect cycle. The first new request can issue in the next cycle if credit allows.
  - Back-to-back redirects: the last one wins, and `drop` is recomputed each time.
- **Halt:**
  - Only request issue is gated.
  - Responses already in flight are still buffered, and the FIFO still drains.
  - Deasserting `halt` resumes fetching at the unchanged `fetch_pc`.
- **Reset mid-operation:** all state returns to reset values immediately. The memory is reset together with this block, so no outstanding response survives.

## Timing
- Issue cycle: the first request after reset deasserts is in the first clock cycle, with `imem_req_addr` = `RESET_PC`.
- Response-to-output latency is 1 cycle: a response in cycle k gives `instr_valid` in cycle k+1. There is no bypass.
- With 1-cycle memory latency and DEPTH=2, the stage sustains 1 instruction/cycle while `instr_ready` stays high.
- Redirect to first valid new instruction is 1 (request) + memory latency + 1 cycles.
- All outputs are registered or decoded from registers. There is no combinational path from `instr_ready` or `imem_resp_*` to `imem_req_valid`.

## Test plan
- **Reset and stream:**
  - Stimulus: `RESET_PC`=0x100, memory latency 1, `instr_ready`=1.
  - Required: `instr_pc` sequence 0x100, 0x104, 0x108… at one per cycle, with `instr_pc_plus` = `instr_pc` + 4.
- **Backpressure:**
  - Stimulus: `instr_ready`=0 for 5 cycles with DEPTH=2.
  - Required: at most 2 requests are accepted, `count` = 2, `imem_req_valid` = 0. After release, no word is lost or duplicated.
- **Redirect with in-flight data:**
  - Stimulus: latency 3 with 2 outstanding requests, then `redirect_pc`=0x2003.
  - Required: both stale responses are dropped, the next request address is 0x2000, and the first `instr_pc` is 0x2000.
- **Redirect coincident with response and pop:**
  - Stimulus: same cycle as `imem_resp_valid` and `instr_ready`.
  - Required: FIFO empty the next cycle, `drop` = `inflight` − 1, and no stale word is ever output.
- **Halt:**
  - Stimulus: assert `halt` while 1 request is in flight.
  - Required: that word is still delivered, no further requests are issued, and after deassertion fetch resumes at the next sequential PC.
- **Async reset and wrap:**
  - Stimulus 1: assert `rst` between clock edges mid-stream. Required: outputs go to reset values without waiting for a clock edge.
  - Stimulus 2: `redirect_pc`=0xFFFF_FFFC. Required: the next address is 0x0000_0000 and `instr_pc_plus` = 0x0.
